// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: arbitrates an instruction path and a cache path onto one
// bundled-data memory port. All request and acknowledge lines are 4-phase.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests. Without it, the instruction path always wins a tie.
//
// Handshake (all channels, return-to-zero): the initiator raises req with
// its data already stable and keeps the data stable while req is high. The
// responder raises ack. The initiator drops req, and then the responder drops
// ack. On the memory side, data_out and PH0 are launched at the grant. They
// stay unchanged until the cycle has fully returned to zero. req_out rises
// only after data_out and PH0 have been stable for HOLD_CYCLES cycles.
module mem_req_arbiter #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_instr,
  input  logic [15:0] data_in_instr,
  output logic        ack_to_instr,
  input  logic        req_cache,
  input  logic [15:0] data_in_cache,
  output logic        ack_to_cache,
  output logic [15:0] data_out,
  output logic [1:0]  PH0,
  output logic        req_out,
  input  logic        ack_in_mem,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_REQ   = 2'd2,
    S_RTZ   = 2'd3
  } state_t;

  localparam logic [1:0] PH_INSTR = 2'b10;
  localparam logic [1:0] PH_CACHE = 2'b00;
  localparam logic [1:0] PH_IDLE  = 2'b11;
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYCLES);

  logic [1:0]  instr_sync, cache_sync, ack_sync;
  logic        req_i_s, req_c_s, ack_s;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        gnt_instr, gnt_instr_nxt;
  logic        aborted, aborted_nxt;
  logic [15:0] data_nxt;
  logic [1:0]  ph0_nxt;
  logic        req_out_nxt, ack_i_nxt, ack_c_nxt;
  logic        gnt_req_s, instr_wins_tie, pick_instr;

  // Two-flop synchronizers for the asynchronous handshake inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_sync <= 2'b00;
      cache_sync <= 2'b00;
      ack_sync   <= 2'b00;
    end else begin
      instr_sync <= {instr_sync[0], req_instr};
      cache_sync <= {cache_sync[0], req_cache};
      ack_sync   <= {ack_sync[0], ack_in_mem};
    end
  end

  assign req_i_s   = instr_sync[1];
  assign req_c_s   = cache_sync[1];
  assign ack_s     = ack_sync[1];
  assign gnt_req_s = gnt_instr ? req_i_s : req_c_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_instr, last_instr_nxt;

  // Last-grant memory. It is updated only when a transaction fully completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_instr <= 1'b0;
    else        last_instr <= last_instr_nxt;
  end

  assign instr_wins_tie = ~last_instr;
`else
  assign instr_wins_tie = 1'b1;
`endif

  assign pick_instr = req_i_s & (~req_c_s | instr_wins_tie);

  // State and registered outputs. Reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      gnt_instr    <= 1'b0;
      aborted      <= 1'b0;
      data_out     <= 16'h0000;
      PH0          <= PH_IDLE;
      req_out      <= 1'b0;
      ack_to_instr <= 1'b0;
      ack_to_cache <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      gnt_instr    <= gnt_instr_nxt;
      aborted      <= aborted_nxt;
      data_out     <= data_nxt;
      PH0          <= ph0_nxt;
      req_out      <= req_out_nxt;
      ack_to_instr <= ack_i_nxt;
      ack_to_cache <= ack_c_nxt;
    end
  end

  // Next-state and output logic. A memory ack seen in IDLE or SETUP is a
  // protocol error, and it freezes progress until the ack is withdrawn.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    gnt_instr_nxt = gnt_instr;
    aborted_nxt   = aborted;
    data_nxt      = data_out;
    ph0_nxt       = PH0;
    req_out_nxt   = req_out;
    ack_i_nxt     = ack_to_instr;
    ack_c_nxt     = ack_to_cache;
`ifdef ARB_ROUND_ROBIN_EN
    last_instr_nxt = last_instr;
`endif
    case (state)
      S_IDLE: begin
        if (!ack_s && (req_i_s || req_c_s)) begin
          gnt_instr_nxt = pick_instr;
          data_nxt      = pick_instr ? data_in_instr : data_in_cache;
          ph0_nxt       = pick_instr ? PH_INSTR : PH_CACHE;
          cnt_nxt       = HOLD_LD;
          aborted_nxt   = 1'b0;
          state_nxt     = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!gnt_req_s) aborted_nxt = 1'b1;
        if (!ack_s) begin
          if (cnt == 4'd0) begin
            req_out_nxt = 1'b1;
            state_nxt   = S_REQ;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end
      S_REQ: begin
        if (!gnt_req_s) aborted_nxt = 1'b1;
        if (ack_s) begin
          req_out_nxt = 1'b0;
          // A requester that gave up mid-transaction is never acknowledged.
          ack_i_nxt   = gnt_instr & gnt_req_s & ~aborted;
          ack_c_nxt   = ~gnt_instr & gnt_req_s & ~aborted;
          state_nxt   = S_RTZ;
        end
      end
      S_RTZ: begin
        if (!ack_s && (aborted || !gnt_req_s)) begin
          ack_i_nxt = 1'b0;
          ack_c_nxt = 1'b0;
          ph0_nxt   = PH_IDLE;
          data_nxt  = 16'h0000;
          state_nxt = S_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          last_instr_nxt = gnt_instr;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign state_dbg = state;

endmodule
